aes256_key_expand: RTL and testbench
====================================

Name: aes256_key_expand

Overview:
- Upstream stage of the AES-256 core. Expands one 256-bit cipher key into 15 round keys (FIPS-197 key schedule).
- Computes iteratively, one 32-bit schedule word per cycle, into an internal round-key store.
- The AES round datapath then reads round keys by index through a registered read port.
- Keeping expansion separate lets one key serve many encrypt/decrypt blocks without recomputation.

Parameters:
- KEY_BW, 256, cipher key width (fixed for AES-256).
- RK_BW, 128, round key width.
- NR, 14, number of rounds; NR+1 = 15 round keys stored.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  single-cycle request to expand `key`; ignored while busy.
- key  in  256  cipher key, MSB = first key byte; sampled only on an accepted start.
- busy  out  1  expansion in progress.
- done  out  1  one-cycle pulse when all 15 round keys are written.
- valid  out  1  round-key store holds a complete schedule for the last accepted key.
- rk_idx  in  4  round-key index, 0..14.
- rk  out  128  round key rk_idx, registered.

Behaviour:
- Reset (async, rst=1):
  - busy=0, done=0, valid=0, rk=0, word counter=0.
  - Store contents are don't-care but are never exposed while valid=0.
- Schedule words w[0..59]:
  - w[0..7] = key split MSB-first.
  - For i = 8..59, w[i] = w[i-8] ^ temp, where:
    - i%8==0: temp = SubWord(RotWord(w[i-1])) ^ {RCON[i/8], 24'h0}.
    - i%8==4: temp = SubWord(w[i-1]).
    - otherwise: temp = w[i-1].
  - RCON[1..7] = 01,02,04,08,10,20,40.
- Datapath:
  - 8-word sliding window register, one 4-byte SubWord stage (4 S-box instances).
  - Round key r = {w[4r], w[4r+1], w[4r+2], w[4r+3]}.
- FSM has two states, IDLE and RUN.
- IDLE:
  - On start=1 at edge E0: latch key into window, write round keys 0 and 1 (key[255:128], key[127:0]), valid<=0, busy<=1, counter<=8, go to RUN.
- RUN:
  - At each edge E1..E52, compute w[counter], shift the window, and increment counter.
  - On completion of each 4-word group, write the next round key (rk 2 at E4, ..., rk 14 at E52).
  - At E52, busy<=0, valid<=1, done<=1, go to IDLE.
  - done is high for exactly the cycle after E52; latency from the start edge to done high is 52 cycles.
- start handling:
  - start during RUN is ignored: no restart, key not resampled.
  - start in IDLE while valid=1 begins a new expansion and drops valid at E0.
- Read port:
  - rk <= store[rk_idx] every cycle; 1-cycle latency.
  - rk_idx > 14 yields rk=0.
  - rk_idx is also readable while valid=0; the value is then undefined and consumers must gate on valid.
- Reset mid-RUN: aborts immediately; outputs return to reset values; no done pulse.
- Simultaneous start and rst: rst wins.

Decomposition:
- aes_pkg holds:
  - Constants: NK=8, NR=14, NUM_RK=15, NUM_WORDS=60.
  - RCON array.
  - Typedefs: word_t (32b), rk_t (128b).
  - Helper functions rot_word and sub_word (wrapping the S-box).
- Sub-module aes_sbox:
  - Combinational 8-bit forward S-box lookup, instantiated 4 times here.
  - Shared with the AES core's SubBytes.

Test Plan:
- FIPS-197 A.3 key 000102...1e1f, start pulse:
  - done high exactly 52 cycles after the start edge; busy high for those 52 cycles; valid=1 afterwards.
  - rk_idx=0 -> 000102030405060708090a0b0c0d0e0f.
  - rk_idx=1 -> 101112131415161718191a1b1c1d1e1f.
  - rk_idx=2 -> a573c29fa176c498a97fce93a572c09c.
  - rk_idx=14 -> 24fc79ccbf0979e9371ac23c6d68de36.
- Read latency: step rk_idx 0..15 on consecutive cycles after valid -> each rk appears one cycle later; idx 15 -> 0.
- start asserted again at cycle 10 of RUN with a different key -> ignored; done still at cycle 52; round key 14 still 24fc79cc...de36.
- rst pulsed at cycle 20 of RUN -> busy, valid, done, rk all 0 immediately; no done pulse; a fresh start afterwards completes correctly.
- All-zero key -> rk_idx=2 gives 62636363626363636263636362636363; back-to-back re-expansion with the A.3 key drops valid at the start edge and restores it with the correct schedule.

Source files
------------

// File: rtl/aes256_key_expand_pkg.sv
// Shared AES-256 key-schedule constants, types and byte/word helpers.
// The forward S-box table lives here so the sbox module and sub_word agree.
package aes256_key_expand_pkg;

  localparam int KEY_BW    = 256;
  localparam int RK_BW     = 128;
  localparam int NK        = 8;
  localparam int NR        = 14;
  localparam int NUM_RK    = NR + 1;
  localparam int NUM_WORDS = 60;

  typedef logic [31:0]      word_t;
  typedef logic [RK_BW-1:0] rk_t;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  // Indexed by i/8; entry 0 is never used by the schedule.
  localparam logic [7:0] RCON [8] = '{8'h00, 8'h01, 8'h02, 8'h04,
                                      8'h08, 8'h10, 8'h20, 8'h40};

  // Byte 0x00 maps to the most significant byte of the table.
  localparam logic [2047:0] SBOX_LUT = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox_fwd(input logic [7:0] a);
    return SBOX_LUT[2047 - 8*int'(a) -: 8];
  endfunction

  function automatic word_t rot_word(input word_t w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic word_t sub_word(input word_t w);
    return {sbox_fwd(w[31:24]), sbox_fwd(w[23:16]), sbox_fwd(w[15:8]), sbox_fwd(w[7:0])};
  endfunction

endpackage

// File: rtl/aes256_key_expand_if.sv
// Control and round-key read bus between the key expander and its consumer.
// master drives requests and read indices; slave is the expander.
interface aes256_key_expand_if;
  import aes256_key_expand_pkg::*;

  logic              start;
  logic [KEY_BW-1:0] key;
  logic              busy;
  logic              done;
  logic              valid;
  logic [3:0]        rk_idx;
  rk_t               rk;

  modport master (
    output start, key, rk_idx,
    input  busy, done, valid, rk
  );

  modport slave (
    input  start, key, rk_idx,
    output busy, done, valid, rk
  );

endinterface

// File: rtl/aes256_key_expand_sbox.sv
// Combinational forward AES S-box, one byte in, one byte out.
// Shared with the cipher core's SubBytes stage.
module aes256_key_expand_sbox
  import aes256_key_expand_pkg::*;
(
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  assign y_o = sbox_fwd(a_i);

endmodule

// File: rtl/aes256_key_expand.sv
// AES-256 key schedule: one word per cycle into a 15-entry round-key store,
// done 52 cycles after an accepted start; round keys read back with 1-cycle latency.
module aes256_key_expand
  import aes256_key_expand_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  aes256_key_expand_if.slave bus
);

  localparam logic [5:0] FIRST_CNT = 6'(NK);
  localparam logic [5:0] LAST_CNT  = 6'(NUM_WORDS - 1);
  localparam logic [3:0] IDX_LIM   = 4'(NUM_RK);

  state_e     state_q, state_d;
  logic [5:0] cnt_q, cnt_d;
  logic       valid_q, valid_d;
  logic       done_q, done_d;
  rk_t        rk_q;

  logic       load, step;
  word_t      win_q [NK];
  rk_t        store_q [NUM_RK];

  word_t      sub_in, sub_out, temp, new_w;

  // ---------------- FSM ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (bus.start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_CNT) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d   = cnt_q;
    valid_d = valid_q;
    done_d  = 1'b0;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          load    = 1'b1;
          cnt_d   = FIRST_CNT;
          valid_d = 1'b0;
        end
      end
      ST_RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST_CNT) begin
          cnt_d   = '0;
          valid_d = 1'b1;
          done_d  = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // ---------------- schedule datapath ----------------
  // win_q[0] is w[i-8], win_q[NK-1] is w[i-1]; cnt_q holds i.
  assign sub_in = cnt_q[2] ? win_q[NK-1] : rot_word(win_q[NK-1]);

  for (genvar b = 0; b < 4; b++) begin : g_sbox
    aes256_key_expand_sbox u_sbox (
      .a_i (sub_in[8*b +: 8]),
      .y_o (sub_out[8*b +: 8])
    );
  end

  always_comb begin
    temp = win_q[NK-1];
    if (cnt_q[1:0] == 2'b00) begin
      temp = cnt_q[2] ? sub_out : (sub_out ^ {RCON[cnt_q[5:3]], 24'h0});
    end
    new_w = win_q[0] ^ temp;
  end

  // Window and store carry no reset: the store is only exposed once valid is set.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int j = 0; j < NK; j++) begin
        win_q[j] <= bus.key[KEY_BW-1-32*j -: 32];
      end
      store_q[0] <= bus.key[KEY_BW-1 -: RK_BW];
      store_q[1] <= bus.key[RK_BW-1:0];
    end else if (step) begin
      for (int j = 0; j < NK-1; j++) begin
        win_q[j] <= win_q[j+1];
      end
      win_q[NK-1] <= new_w;
      if (cnt_q[1:0] == 2'b11) begin
        store_q[cnt_q[5:2]] <= {win_q[NK-3], win_q[NK-2], win_q[NK-1], new_w};
      end
    end
  end

  // ---------------- read port ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rk_q <= '0;
    end else begin
      rk_q <= (bus.rk_idx < IDX_LIM) ? store_q[bus.rk_idx] : '0;
    end
  end

  assign bus.busy  = (state_q == ST_RUN);
  assign bus.done  = done_q;
  assign bus.valid = valid_q;
  assign bus.rk    = rk_q;

endmodule

// File: tb/tb_aes256_key_expand.sv
// Directed bench for the AES-256 key expander against FIPS-197 schedule values.
module tb_aes256_key_expand;
  import aes256_key_expand_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  aes256_key_expand_if bus();

  aes256_key_expand dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  localparam logic [255:0] KEY_A3   = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [255:0] KEY_ZERO = 256'h0;
  localparam logic [255:0] KEY_ALT  = 256'hdeadbeefcafef00d0123456789abcdeffedcba9876543210a5a5a5a55a5a5a5a;

  rk_t exp_a3 [16];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Presents start/key for one edge (E0); returns #1 after E0.
  task automatic kick(input logic [255:0] k);
    bus.key   = k;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  // Counts cycles after E0 until done; optionally re-asserts start at edge poke_at.
  task automatic wait_done(input int poke_at, input logic [255:0] poke_key,
                           output int done_at, output int busy_cycles);
    done_at     = -1;
    busy_cycles = 0;
    for (int c = 1; c <= 80 && done_at < 0; c++) begin
      if (bus.busy) busy_cycles++;
      if (c == poke_at) begin
        bus.key   = poke_key;
        bus.start = 1'b1;
      end
      @(posedge clk); #1;
      bus.start = 1'b0;
      if (bus.done) done_at = c;
    end
  endtask

  task automatic read_rk(input logic [3:0] idx, output rk_t v);
    bus.rk_idx = idx;
    @(posedge clk); #1;
    v = bus.rk;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int   done_at, busy_cycles, pulses;
    rk_t  v;

    exp_a3 = '{
      128'h000102030405060708090a0b0c0d0e0f, 128'h101112131415161718191a1b1c1d1e1f,
      128'ha573c29fa176c498a97fce93a572c09c, 128'h1651a8cd0244beda1a5da4c10640bade,
      128'hae87dff00ff11b68a68ed5fb03fc1567, 128'h6de1f1486fa54f9275f8eb5373b8518d,
      128'hc656827fc9a799176f294cec6cd5598b, 128'h3de23a75524775e727bf9eb45407cf39,
      128'h0bdc905fc27b0948ad5245a4c1871c2f, 128'h45f5a66017b2d387300d4d33640a820a,
      128'h7ccff71cbeb4fe5413e6bbf0d261a7df, 128'hf01afafee7a82979d7a5644ab3afe640,
      128'h2541fe719bf500258813bbd55a721c0a, 128'h4e5a6699a9f24fe07e572baacdf8cdea,
      128'h24fc79ccbf0979e9371ac23c6d68de36, 128'h0
    };

    bus.start  = 1'b0;
    bus.key    = '0;
    bus.rk_idx = 4'd0;

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy",  128'(bus.busy),  128'(0));
    chk("rst_done",  128'(bus.done),  128'(0));
    chk("rst_valid", 128'(bus.valid), 128'(0));
    chk("rst_rk",    bus.rk,          128'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // A.3 key expansion: timing and flags
    kick(KEY_A3);
    chk("a3_busy_e0", 128'(bus.busy), 128'(1));
    wait_done(0, KEY_ZERO, done_at, busy_cycles);
    chk("a3_done_cyc",   128'(done_at),     128'(52));
    chk("a3_busy_cyc",   128'(busy_cycles), 128'(52));
    chk("a3_busy_end",   128'(bus.busy),    128'(0));
    chk("a3_valid_done", 128'(bus.valid),   128'(1));
    @(posedge clk); #1;
    chk("a3_done_pulse", 128'(bus.done),    128'(0));
    chk("a3_valid_hold", 128'(bus.valid),   128'(1));

    read_rk(4'd0,  v); chk("a3_rk0",  v, exp_a3[0]);
    read_rk(4'd1,  v); chk("a3_rk1",  v, exp_a3[1]);
    read_rk(4'd2,  v); chk("a3_rk2",  v, exp_a3[2]);
    read_rk(4'd14, v); chk("a3_rk14", v, exp_a3[14]);

    // Read latency sweep, idx 15 reads zero
    bus.rk_idx = 4'd0;
    for (int i = 1; i <= 16; i++) begin
      @(posedge clk); #1;
      chk($sformatf("rd_lat%0d", i-1), bus.rk, exp_a3[i-1]);
      if (i < 16) bus.rk_idx = 4'(i);
    end

    // start during RUN is ignored
    kick(KEY_A3);
    chk("rs_valid_e0", 128'(bus.valid), 128'(0));
    wait_done(10, KEY_ALT, done_at, busy_cycles);
    chk("rs_done_cyc", 128'(done_at), 128'(52));
    @(posedge clk); #1;
    chk("rs_busy_after", 128'(bus.busy), 128'(0));
    read_rk(4'd14, v); chk("rs_rk14", v, exp_a3[14]);
    read_rk(4'd0,  v); chk("rs_rk0",  v, exp_a3[0]);

    // Reset mid-RUN
    bus.rk_idx = 4'd14;
    kick(KEY_ALT);
    repeat (20) begin @(posedge clk); #1; end
    rst = 1'b1;
    #1;
    chk("mr_busy",  128'(bus.busy),  128'(0));
    chk("mr_valid", 128'(bus.valid), 128'(0));
    chk("mr_done",  128'(bus.done),  128'(0));
    chk("mr_rk",    bus.rk,          128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    pulses = 0;
    repeat (60) begin
      @(posedge clk); #1;
      if (bus.done) pulses++;
    end
    chk("mr_no_done", 128'(pulses),    128'(0));
    chk("mr_idle",    128'(bus.busy),  128'(0));
    kick(KEY_A3);
    wait_done(0, KEY_ZERO, done_at, busy_cycles);
    chk("mr_done_cyc", 128'(done_at), 128'(52));
    read_rk(4'd14, v); chk("mr_rk14", v, exp_a3[14]);
    read_rk(4'd3,  v); chk("mr_rk3",  v, exp_a3[3]);

    // All-zero key, then back-to-back A.3 re-expansion
    kick(KEY_ZERO);
    wait_done(0, KEY_ZERO, done_at, busy_cycles);
    chk("z_done_cyc", 128'(done_at), 128'(52));
    read_rk(4'd2, v); chk("z_rk2", v, 128'h62636363626363636263636362636363);
    read_rk(4'd0, v); chk("z_rk0", v, 128'h0);
    kick(KEY_A3);
    chk("bb_valid_drop", 128'(bus.valid), 128'(0));
    chk("bb_busy",       128'(bus.busy),  128'(1));
    wait_done(0, KEY_ZERO, done_at, busy_cycles);
    chk("bb_done_cyc", 128'(done_at),   128'(52));
    chk("bb_valid",    128'(bus.valid), 128'(1));
    read_rk(4'd2,  v); chk("bb_rk2",  v, exp_a3[2]);
    read_rk(4'd14, v); chk("bb_rk14", v, exp_a3[14]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
